vga_rx_monitor: RTL and testbench

Receiving end of the VGA display interface: consumes the `hsync`/`vsync`/`rgb` stream produced by the VGA top level and rebuilds pixel coordinates from the sync edges alone. It checks 640x480@60 timing, locks onto the frame and reports a per-frame checksum of the active-area pixels. It sits beside the display path, in simulation benches and in the on-chip self-check, driven by the same pixel-rate strobe as the generator.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_sync_edge.sv | 32 +++
 rtl/vga_rx_monitor.sv | 170 +++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, derived sync positions and
// the monitor FSM encoding, shared by the VGA generator and the receive monitor.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam bit VGA_SYNC_POL = 1'b0;   // 0 = syncs are active-low

   localparam int VGA_H_TOT = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;   // 800
   localparam int VGA_V_TOT = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;   // 525

   // Sync pulses start right after the front porch and last for the pulse width.
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;        // 656
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;  // 752
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;        // 490
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;  // 492

   // Horizontal and vertical position counters.
   typedef logic [9:0] cnt_t;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } mon_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: pix_en-qualified assert/deassert detector for one sync line.
// The level is normalised through POL so 1 always means "sync asserted".
module vga_sync_edge #(
   parameter bit POL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pix_en,
   input  logic sync_i,
   output logic rise_o,
   output logic fall_o
);

   logic level;
   logic level_q;

   assign level = (sync_i == POL);

   // Remember the normalised level seen at the previous pixel sample.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         level_q <= 1'b0;
      end else if (pix_en) begin
         level_q <= level;
      end
   end

   assign rise_o = pix_en &  level & ~level_q;
   assign fall_o = pix_en & ~level &  level_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: rebuilds pixel coordinates from the VGA sync edges, verifies
// the sync timing, locks onto the frame and reports a per-frame active-area checksum.
module vga_rx_monitor
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = VGA_SYNC_POL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic        locked,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        active,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic        timing_err,
   output logic [7:0]  err_cnt
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
   localparam cnt_t H_SS   = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_SE   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_SS   = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_SE   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);

   logic       hs_rise, hs_fall, vs_rise, vs_fall;
   cnt_t       h_q, v_q, h_d, v_d, h_pred, v_pred;
   mon_state_e state_q;
   logic       locked_q, active_q, frame_done_q, timing_err_q;
   logic [15:0] acc_q, frame_sum_q;
   logic [7:0]  err_cnt_q;
   logic       viol, locked_d, in_area;

   vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en),
      .sync_i (hsync),
      .rise_o (hs_rise),
      .fall_o (hs_fall)
   );

   vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en),
      .sync_i (vsync),
      .rise_o (vs_rise),
      .fall_o (vs_fall)
   );

   // Predict the next raster position, then let sync asserts override it.
   always_comb begin
      // NOTE: every output of this block is given a value first so no path can infer a latch.
      h_pred = (h_q == H_LAST) ? '0 : h_q + cnt_t'(1);
      v_pred = v_q;
      if (h_q == H_LAST) begin
         v_pred = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
      end
      h_d = h_pred;
      v_d = v_pred;
      if (hs_rise) begin
         h_d = H_SS;
      end
      if (vs_rise) begin
         v_d = V_SS;
         h_d = '0;
      end
   end

   // Any sync edge that disagrees with the predicted position is one violation.
   assign viol = (hs_rise != (h_pred == H_SS))
              || (hs_fall && (h_pred != H_SE))
              || (vs_rise != ((v_pred == V_SS) && (h_pred == '0)))
              || (vs_fall && !((v_pred == V_SE) && (h_pred == '0)));

   // Locked after this sample: a clean vsync in CHECK, or a clean sample in LOCKED.
   assign locked_d = (state_q != ST_SEARCH) && !viol
                  && (vs_rise || (state_q == ST_LOCKED));
   assign in_area  = (h_d < H_ACT) && (v_d < V_ACT);

   // Position counters advance once per pixel sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else if (pix_en) begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Lock FSM with its registered status, checksum and error outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SEARCH;
         locked_q     <= 1'b0;
         active_q     <= 1'b0;
         frame_done_q <= 1'b0;
         timing_err_q <= 1'b0;
         acc_q        <= '0;
         frame_sum_q  <= '0;
         err_cnt_q    <= '0;
      end else begin
         frame_done_q <= 1'b0;
         timing_err_q <= 1'b0;
         if (pix_en) begin
            locked_q <= locked_d;
            active_q <= locked_d && in_area;
            unique case (state_q)
               ST_SEARCH: begin
                  acc_q <= '0;
                  if (vs_rise) begin
                     state_q <= ST_CHECK;
                  end
               end
               ST_CHECK, ST_LOCKED: begin
                  if (viol) begin
                     state_q      <= ST_SEARCH;
                     acc_q        <= '0;
                     timing_err_q <= 1'b1;
                     if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                     end
                  end else if (vs_rise) begin
                     state_q      <= ST_LOCKED;
                     frame_sum_q  <= acc_q;
                     frame_done_q <= 1'b1;
                     acc_q        <= '0;
                  end else if (in_area) begin
                     acc_q <= acc_q + {4'b0, rgb};
                  end
               end
               default: begin
                  state_q <= ST_SEARCH;
                  acc_q   <= '0;
               end
            endcase
         end
      end
   end

   assign locked     = locked_q;
   assign pix_x      = h_q;
   assign pix_y      = v_q;
   assign active     = active_q;
   assign frame_done = frame_done_q;
   assign frame_sum  = frame_sum_q;
   assign timing_err = timing_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: drives a reduced-size VGA raster with random gaps between
// pixel strobes and compares every output against a linear-position reference model.
module tb_vga_rx_monitor;

   localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
   localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
   localparam bit POL = 1'b0;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int HS0 = HA + HFP, HS1 = HS0 + HSW;
   localparam int VS0 = VA + VFP, VS1 = VS0 + VSW;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b0;
   logic        hsync = ~POL;
   logic        vsync = ~POL;
   logic [11:0] rgb = 12'h0;
   logic        locked, active, frame_done, timing_err;
   logic [9:0]  pix_x, pix_y;
   logic [15:0] frame_sum;
   logic [7:0]  err_cnt;

   vga_rx_monitor #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .SYNC_POL(POL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_en     (pix_en),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb),
      .locked     (locked),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .active     (active),
      .frame_done (frame_done),
      .frame_sum  (frame_sum),
      .timing_err (timing_err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int gap_max = 2;

   // Reference model: position kept as one linear pixel index within the frame.
   int m_pos, m_phase, m_acc;   // phase: 0 hunting, 1 verifying first frame, 2 locked
   bit m_prev_hs, m_prev_vs;
   int e_locked, e_active, e_done, e_terr, e_sum, e_cnt, e_x, e_y;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_phase = 0; m_acc = 0;
      m_prev_hs = 1'b0; m_prev_vs = 1'b0;
      e_locked = 0; e_active = 0; e_done = 0; e_terr = 0;
      e_sum = 0; e_cnt = 0; e_x = 0; e_y = 0;
   endtask

   task automatic model_sample(input bit hs_l, input bit vs_l, input logic [11:0] c);
      int  pred, pos;
      bit  hr, hf, vr, vf, bad;
      pred = (m_pos + 1) % FRAME;
      hr = hs_l && !m_prev_hs;
      hf = !hs_l && m_prev_hs;
      vr = vs_l && !m_prev_vs;
      vf = !vs_l && m_prev_vs;
      m_prev_hs = hs_l;
      m_prev_vs = vs_l;
      bad = (hr != ((pred % HT) == HS0)) || (hf && ((pred % HT) != HS1))
         || (vr != (pred == VS0 * HT)) || (vf && (pred != VS1 * HT));
      pos = pred;
      if (hr) pos = (pred / HT) * HT + HS0;
      if (vr) pos = VS0 * HT;
      e_done = 0;
      e_terr = 0;
      if (m_phase == 0) begin
         m_acc = 0;
         if (vr) m_phase = 1;
      end else if (bad) begin
         m_phase = 0;
         m_acc = 0;
         e_terr = 1;
         e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
      end else if (vr) begin
         m_phase = 2;
         e_sum = m_acc;
         e_done = 1;
         m_acc = 0;
      end else if ((pos % HT) < HA && (pos / HT) < VA) begin
         m_acc = (m_acc + int'(c)) % 65536;
      end
      m_pos = pos;
      e_x = pos % HT;
      e_y = pos / HT;
      e_locked = (m_phase == 2) ? 1 : 0;
      e_active = (e_locked == 1 && e_x < HA && e_y < VA) ? 1 : 0;
   endtask

   task automatic compare_all();
      check("locked", 32'(locked), 32'(e_locked));
      check("active", 32'(active), 32'(e_active));
      check("frame_done", 32'(frame_done), 32'(e_done));
      check("timing_err", 32'(timing_err), 32'(e_terr));
      check("frame_sum", 32'(frame_sum), 32'(e_sum));
      check("err_cnt", 32'(err_cnt), 32'(e_cnt));
      check("pix_x", 32'(pix_x), 32'(e_x));
      check("pix_y", 32'(pix_y), 32'(e_y));
   endtask

   // One clk: drive inputs, let the edge happen, update the model, compare.
   task automatic apply(input bit pen, input bit hs_l, input bit vs_l, input logic [11:0] c);
      pix_en = pen;
      hsync  = POL ? hs_l : ~hs_l;
      vsync  = POL ? vs_l : ~vs_l;
      rgb    = c;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (pen) begin
         model_sample(hs_l, vs_l, c);
      end else begin
         e_done = 0;
         e_terr = 0;
      end
      #1;
      compare_all();
   endtask

   // One pixel sample preceded by a random number of idle clks with junk inputs.
   task automatic drive_sample(input bit hs_l, input bit vs_l, input logic [11:0] c);
      int gap;
      gap = int'($urandom_range(gap_max));
      for (int i = 0; i < gap; i++) begin
         apply(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
      end
      apply(1'b1, hs_l, vs_l, c);
   endtask

   // Raster lines from line 0. mode: 0 random rgb, 1 white, 2 rgb = column.
   // kind: 1 line one pixel short, 2 hsync one pixel narrow.
   task automatic run_lines(input int nlines, input int mode, input int flt_line,
                            input int flt_kind, input int rand_pct);
      int kind, last, y;
      bit hs_l, vs_l;
      logic [11:0] c;
      for (int ln = 0; ln < nlines; ln++) begin
         y = ln % VT;
         kind = (ln == flt_line) ? flt_kind : 0;
         if (rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
            kind = int'($urandom_range(2, 1));
         end
         last = (kind == 1) ? HT - 2 : HT - 1;
         for (int x = 0; x <= last; x++) begin
            hs_l = (x >= HS0) && (x < ((kind == 2) ? HS1 - 1 : HS1));
            vs_l = (y >= VS0) && (y < VS1);
            case (mode)
               0:       c = 12'($urandom);
               1:       c = 12'hFFF;
               default: c = 12'(x);
            endcase
            drive_sample(hs_l, vs_l, c);
         end
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset_async();
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      check("rst_async_locked", 32'(locked), 32'd0);
      check("rst_async_sum", 32'(frame_sum), 32'd0);
      repeat (2) apply(1'b0, 1'b0, 1'b0, 12'h0);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) apply(1'b0, 1'b0, 1'b0, 12'h0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      reset = 1'b0;

      // Clean white frames: lock at the second vsync, checksum of a full white area.
      run_lines(3 * VT, 1, -1, 0, 0);
      check("sum_white", 32'(frame_sum), 32'((HA * VA * 4095) % 65536));
      check("lock_white", 32'(locked), 32'd1);
      check("err_clean", 32'(err_cnt), 32'd0);

      // Column-valued pixels.
      run_lines(2 * VT, 2, -1, 0, 0);
      check("sum_column", 32'(frame_sum), 32'((VA * (HA * (HA - 1) / 2)) % 65536));

      // One short line while locked, then relock.
      run_lines(3 * VT, 0, 3, 1, 0);
      check("err_short_line", 32'(err_cnt), 32'd1);
      check("relock_short", 32'(locked), 32'd1);

      // One narrow hsync pulse, then relock.
      run_lines(3 * VT, 0, 5, 2, 0);
      check("err_narrow_hs", 32'(err_cnt), 32'd2);
      check("relock_narrow", 32'(locked), 32'd1);

      // Asynchronous reset in the middle of a locked frame.
      run_lines(6, 0, -1, 0, 0);
      pulse_reset_async();
      run_lines(2 * VT, 0, -1, 0, 0);
      check("relock_after_rst", 32'(locked), 32'd1);
      check("err_after_rst", 32'(err_cnt), 32'd0);

      // Toggling vsync every sample forces a violation every other sample.
      for (int i = 0; i < 650; i++) begin
         drive_sample(1'b0, (i % 2) == 0, 12'($urandom));
      end
      check("err_saturated", 32'(err_cnt), 32'd255);

      // Random frames with sporadic faults and wider strobe gaps.
      pulse_reset_async();
      gap_max = 3;
      run_lines(8 * VT, 0, -1, 0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
